// File: rtl/stopwatch_ctrl_if.sv
// Control/status bundle between the stopwatch mode sequencer and its
// surroundings: debounced buttons and datapath flags in, counter commands out.
interface stopwatch_ctrl_if #(
    parameter int TW = 23
);
    logic          ms_tick;
    logic          startstop;
    logic          prog;
    logic          increment;
    logic          min;
    logic          up;
    logic          clear;
    logic          t_at_zero;
    logic          t_at_max;

    logic          cnt_en;
    logic          cnt_up;
    logic          cnt_load;
    logic [TW-1:0] load_val;
    logic [TW-1:0] preset;
    logic          alarm;
    logic          blinker;
    logic [2:0]    state;

    modport master (
        output ms_tick, startstop, prog, increment, min, up, clear,
        output t_at_zero, t_at_max,
        input  cnt_en, cnt_up, cnt_load, load_val, preset,
        input  alarm, blinker, state
    );

    modport slave (
        input  ms_tick, startstop, prog, increment, min, up, clear,
        input  t_at_zero, t_at_max,
        output cnt_en, cnt_up, cnt_load, load_val, preset,
        output alarm, blinker, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode sequencer: turns button levels into counter commands,
// owns the countdown preset, and raises alarm/blinker.
module stopwatch_ctrl #(
    parameter int TW            = 23,
    parameter int MAX_PRESET_MS = 5999000,
    parameter int SEC_STEP_MS   = 1000,
    parameter int MIN_STEP_MS   = 60000,
    parameter int BLINK_MS      = 250
) (
    input  logic             clock,
    input  logic             reset,
    stopwatch_ctrl_if.slave  sw
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PAUSE   = 3'd2,
        PROG    = 3'd3,
        EXPIRED = 3'd4
    } state_e;

    localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    localparam logic [TW:0]   SEC_STEP = (TW+1)'(SEC_STEP_MS);
    localparam logic [TW:0]   MIN_STEP = (TW+1)'(MIN_STEP_MS);
    localparam logic [TW:0]   MAX_PRE  = (TW+1)'(MAX_PRESET_MS);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_MS - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] preset_q, preset_d;
    logic          ss_q, inc_q;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blinker_q, blinker_d;
    logic          alarm_q, alarm_d;

    logic          ss_edge;
    logic          inc_edge;
    logic [TW:0]   step;
    logic [TW:0]   sum;
    logic          blink_on;

    assign ss_edge  = sw.startstop & ~ss_q;
    assign inc_edge = sw.increment & ~inc_q;

    // One extra bit so the overflow test sees the true sum
    assign step = sw.min ? MIN_STEP : SEC_STEP;
    assign sum  = {1'b0, preset_q} + step;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (sw.prog)
                    state_d = PROG;
                else if (ss_edge)
                    state_d = RUN;
            end
            PROG: begin
                if (!sw.prog)
                    state_d = IDLE;
            end
            RUN: begin
                if (sw.clear)
                    state_d = IDLE;
                else if (ss_edge)
                    state_d = PAUSE;
                else if (!sw.up && sw.t_at_zero)
                    state_d = EXPIRED;
                else if (sw.up && sw.t_at_max)
                    state_d = PAUSE;
            end
            PAUSE: begin
                if (sw.clear)
                    state_d = IDLE;
                else if (ss_edge)
                    state_d = RUN;
            end
            EXPIRED: begin
                if (sw.clear || ss_edge)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        preset_d = preset_q;
        if (state_q == PROG && inc_edge) begin
            if (sum > MAX_PRE)
                preset_d = '0;
            else
                preset_d = sum[TW-1:0];
        end
    end

    // Blink phase restarts on every entry into PROG or EXPIRED
    assign blink_on = (state_d == PROG) || (state_d == EXPIRED);

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blinker_d   = blinker_q;
        if (!blink_on || state_d != state_q) begin
            blink_cnt_d = '0;
            blinker_d   = 1'b0;
        end else if (sw.ms_tick) begin
            if (blink_cnt_q == BLK_LAST) begin
                blink_cnt_d = '0;
                blinker_d   = ~blinker_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    assign alarm_d = (state_d == EXPIRED);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            preset_q    <= '0;
            ss_q        <= 1'b0;
            inc_q       <= 1'b0;
            blink_cnt_q <= '0;
            blinker_q   <= 1'b0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            preset_q    <= preset_d;
            ss_q        <= sw.startstop;
            inc_q       <= sw.increment;
            blink_cnt_q <= blink_cnt_d;
            blinker_q   <= blinker_d;
            alarm_q     <= alarm_d;
        end
    end

    assign sw.cnt_en   = sw.ms_tick & (state_q == RUN);
    assign sw.cnt_up   = sw.up;
    assign sw.cnt_load = (state_q == IDLE) || (state_q == PROG);
    assign sw.load_val = sw.up ? '0 : preset_q;
    assign sw.preset   = preset_q;
    assign sw.alarm    = alarm_q;
    assign sw.blinker  = blinker_q;
    assign sw.state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl; BLINK_MS shrunk to 4 so blink
// periods fit in a few cycles.
module tb_stopwatch_ctrl;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    stopwatch_ctrl_if #(.TW(23)) sw_if ();

    stopwatch_ctrl #(
        .TW(23), .MAX_PRESET_MS(5999000), .SEC_STEP_MS(1000),
        .MIN_STEP_MS(60000), .BLINK_MS(4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .sw    (sw_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (sw_if.state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", sw_if.state); end
        checks++; if (sw_if.preset !== 23'd0) begin failures++; $display("FAIL rst_preset got=%0d exp=0", sw_if.preset); end
        checks++; if (sw_if.alarm !== 1'b0) begin failures++; $display("FAIL rst_alarm got=%b exp=0", sw_if.alarm); end
        checks++; if (sw_if.blinker !== 1'b0) begin failures++; $display("FAIL rst_blinker got=%b exp=0", sw_if.blinker); end
        checks++; if (sw_if.cnt_load !== 1'b1) begin failures++; $display("FAIL rst_cnt_load got=%b exp=1", sw_if.cnt_load); end
        checks++; if (sw_if.cnt_up !== 1'b1) begin failures++; $display("FAIL rst_cnt_up got=%b exp=1", sw_if.cnt_up); end
        checks++; if (sw_if.load_val !== 23'd0) begin failures++; $display("FAIL rst_load_val got=%0d exp=0", sw_if.load_val); end
        sw_if.ms_tick = 1'b1;
        #1;
        checks++; if (sw_if.cnt_en !== 1'b0) begin failures++; $display("FAIL rst_cnt_en got=%b exp=0", sw_if.cnt_en); end
        sw_if.ms_tick = 1'b0;
        reset = 1'b0;
        step();
    endtask

    task automatic test_run_pause();
        int en_cnt;
        en_cnt = 0;
        sw_if.up = 1'b1;
        sw_if.startstop = 1'b1;
        step();
        sw_if.startstop = 1'b0;
        checks++; if (sw_if.state !== 3'd1) begin failures++; $display("FAIL run_enter got=%0d exp=1", sw_if.state); end
        checks++; if (sw_if.cnt_load !== 1'b0) begin failures++; $display("FAIL run_cnt_load got=%b exp=0", sw_if.cnt_load); end
        for (int i = 0; i < 5; i++) begin
            sw_if.ms_tick = 1'b1;
            #1;
            if (sw_if.cnt_en === 1'b1) en_cnt++;
            step();
            sw_if.ms_tick = 1'b0;
            #1;
            if (sw_if.cnt_en !== 1'b0) en_cnt += 100;
            step();
        end
        checks++; if (en_cnt !== 5) begin failures++; $display("FAIL run_en_pulses got=%0d exp=5", en_cnt); end
        sw_if.up = 1'b0;
        #1;
        checks++; if (sw_if.cnt_up !== 1'b0) begin failures++; $display("FAIL run_cnt_up got=%b exp=0", sw_if.cnt_up); end
        step();
        checks++; if (sw_if.state !== 3'd1) begin failures++; $display("FAIL run_up_change got=%0d exp=1", sw_if.state); end
        sw_if.up = 1'b1;
        sw_if.startstop = 1'b1;
        step();
        sw_if.startstop = 1'b0;
        checks++; if (sw_if.state !== 3'd2) begin failures++; $display("FAIL pause_enter got=%0d exp=2", sw_if.state); end
        sw_if.ms_tick = 1'b1;
        #1;
        checks++; if (sw_if.cnt_en !== 1'b0) begin failures++; $display("FAIL pause_cnt_en got=%b exp=0", sw_if.cnt_en); end
        checks++; if (sw_if.cnt_load !== 1'b0) begin failures++; $display("FAIL pause_cnt_load got=%b exp=0", sw_if.cnt_load); end
        sw_if.ms_tick = 1'b0;
        sw_if.clear = 1'b1;
        step();
        sw_if.clear = 1'b0;
        checks++; if (sw_if.state !== 3'd0) begin failures++; $display("FAIL pause_clear got=%0d exp=0", sw_if.state); end
        checks++; if (sw_if.cnt_load !== 1'b1) begin failures++; $display("FAIL idle_cnt_load got=%b exp=1", sw_if.cnt_load); end
    endtask

    task automatic test_prog();
        sw_if.prog = 1'b1;
        sw_if.startstop = 1'b1;
        step();
        sw_if.startstop = 1'b0;
        checks++; if (sw_if.state !== 3'd3) begin failures++; $display("FAIL prog_enter got=%0d exp=3", sw_if.state); end
        sw_if.min = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sw_if.increment = 1'b1;
            step();
            sw_if.increment = 1'b0;
            step();
        end
        checks++; if (sw_if.preset !== 23'd120000) begin failures++; $display("FAIL prog_min got=%0d exp=120000", sw_if.preset); end
        sw_if.min = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sw_if.increment = 1'b1;
            step();
            step();
            step();
            sw_if.increment = 1'b0;
            step();
        end
        checks++; if (sw_if.state !== 3'd3) begin failures++; $display("FAIL prog_hold got=%0d exp=3", sw_if.state); end
        sw_if.prog = 1'b0;
        step();
        checks++; if (sw_if.preset !== 23'd123000) begin failures++; $display("FAIL prog_preset got=%0d exp=123000", sw_if.preset); end
        checks++; if (sw_if.state !== 3'd0) begin failures++; $display("FAIL prog_exit got=%0d exp=0", sw_if.state); end
        sw_if.up = 1'b0;
        #1;
        checks++; if (sw_if.load_val !== 23'd123000) begin failures++; $display("FAIL prog_load_val got=%0d exp=123000", sw_if.load_val); end
        sw_if.up = 1'b1;
        #1;
        checks++; if (sw_if.load_val !== 23'd0) begin failures++; $display("FAIL up_load_val got=%0d exp=0", sw_if.load_val); end
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        step();
        reset = 1'b0;
        sw_if.prog = 1'b1;
        step();
        sw_if.min = 1'b1;
        for (int i = 0; i < 99; i++) begin
            sw_if.increment = 1'b1;
            step();
            sw_if.increment = 1'b0;
            step();
        end
        checks++; if (sw_if.preset !== 23'd5940000) begin failures++; $display("FAIL wrap_pre got=%0d exp=5940000", sw_if.preset); end
        sw_if.increment = 1'b1;
        step();
        sw_if.increment = 1'b0;
        step();
        checks++; if (sw_if.preset !== 23'd0) begin failures++; $display("FAIL wrap_zero got=%0d exp=0", sw_if.preset); end
        sw_if.min = 1'b0;
        sw_if.increment = 1'b1;
        step();
        sw_if.increment = 1'b0;
        step();
        checks++; if (sw_if.preset !== 23'd1000) begin failures++; $display("FAIL wrap_sec got=%0d exp=1000", sw_if.preset); end
        sw_if.prog = 1'b0;
        step();
    endtask

    task automatic test_expire();
        sw_if.up = 1'b0;
        sw_if.startstop = 1'b1;
        step();
        sw_if.startstop = 1'b0;
        checks++; if (sw_if.state !== 3'd1) begin failures++; $display("FAIL exp_run got=%0d exp=1", sw_if.state); end
        sw_if.t_at_zero = 1'b1;
        step();
        checks++; if (sw_if.state !== 3'd4) begin failures++; $display("FAIL exp_state got=%0d exp=4", sw_if.state); end
        checks++; if (sw_if.alarm !== 1'b1) begin failures++; $display("FAIL exp_alarm got=%b exp=1", sw_if.alarm); end
        sw_if.ms_tick = 1'b1;
        #1;
        checks++; if (sw_if.cnt_en !== 1'b0) begin failures++; $display("FAIL exp_cnt_en got=%b exp=0", sw_if.cnt_en); end
        sw_if.ms_tick = 1'b0;
        sw_if.t_at_zero = 1'b0;
        sw_if.startstop = 1'b1;
        step();
        sw_if.startstop = 1'b0;
        checks++; if (sw_if.state !== 3'd0) begin failures++; $display("FAIL exp_leave got=%0d exp=0", sw_if.state); end
        checks++; if (sw_if.alarm !== 1'b0) begin failures++; $display("FAIL exp_alarm_off got=%b exp=0", sw_if.alarm); end
        sw_if.up = 1'b1;
        step();
    endtask

    task automatic test_blink();
        logic exp_b;
        sw_if.up = 1'b0;
        sw_if.t_at_zero = 1'b1;
        sw_if.startstop = 1'b1;
        step();
        sw_if.startstop = 1'b0;
        step();
        checks++; if (sw_if.state !== 3'd4) begin failures++; $display("FAIL blink_enter got=%0d exp=4", sw_if.state); end
        sw_if.ms_tick = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_b = ((k / 4) % 2) == 1;
            checks++; if (sw_if.blinker !== exp_b) begin failures++; $display("FAIL blink_k%0d got=%b exp=%b", k, sw_if.blinker, exp_b); end
        end
        sw_if.ms_tick = 1'b0;
        sw_if.clear = 1'b1;
        step();
        sw_if.clear = 1'b0;
        sw_if.t_at_zero = 1'b0;
        checks++; if (sw_if.blinker !== 1'b0) begin failures++; $display("FAIL blink_idle got=%b exp=0", sw_if.blinker); end
        sw_if.up = 1'b1;
        sw_if.startstop = 1'b1;
        step();
        sw_if.startstop = 1'b0;
        step();
        sw_if.startstop = 1'b1;
        sw_if.clear = 1'b1;
        step();
        sw_if.startstop = 1'b0;
        sw_if.clear = 1'b0;
        checks++; if (sw_if.state !== 3'd0) begin failures++; $display("FAIL clear_wins got=%0d exp=0", sw_if.state); end
        step();
    endtask

    task automatic test_saturate();
        sw_if.up = 1'b1;
        sw_if.startstop = 1'b1;
        step();
        sw_if.startstop = 1'b0;
        sw_if.t_at_max = 1'b1;
        step();
        checks++; if (sw_if.state !== 3'd2) begin failures++; $display("FAIL sat_pause got=%0d exp=2", sw_if.state); end
        sw_if.prog = 1'b1;
        step();
        sw_if.prog = 1'b0;
        checks++; if (sw_if.state !== 3'd2) begin failures++; $display("FAIL sat_prog_ign got=%0d exp=2", sw_if.state); end
        sw_if.startstop = 1'b1;
        step();
        sw_if.startstop = 1'b0;
        checks++; if (sw_if.state !== 3'd1) begin failures++; $display("FAIL sat_resume got=%0d exp=1", sw_if.state); end
        step();
        checks++; if (sw_if.state !== 3'd2) begin failures++; $display("FAIL sat_repause got=%0d exp=2", sw_if.state); end
        sw_if.t_at_max = 1'b0;
        sw_if.clear = 1'b1;
        step();
        sw_if.clear = 1'b0;
    endtask

    task automatic test_back_to_back();
        int    trans;
        logic [2:0] prev;
        trans = 0;
        prev = sw_if.state;
        sw_if.startstop = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sw_if.state !== prev) trans++;
            prev = sw_if.state;
        end
        sw_if.startstop = 1'b0;
        checks++; if (trans !== 1) begin failures++; $display("FAIL hold_trans got=%0d exp=1", trans); end
        checks++; if (sw_if.state !== 3'd1) begin failures++; $display("FAIL hold_state got=%0d exp=1", sw_if.state); end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (sw_if.state !== 3'd0) begin failures++; $display("FAIL rst_run_state got=%0d exp=0", sw_if.state); end
        checks++; if (sw_if.preset !== 23'd0) begin failures++; $display("FAIL rst_run_preset got=%0d exp=0", sw_if.preset); end
        checks++; if (sw_if.alarm !== 1'b0) begin failures++; $display("FAIL rst_run_alarm got=%b exp=0", sw_if.alarm); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        sw_if.ms_tick   = 1'b0;
        sw_if.startstop = 1'b0;
        sw_if.prog      = 1'b0;
        sw_if.increment = 1'b0;
        sw_if.min       = 1'b0;
        sw_if.up        = 1'b1;
        sw_if.clear     = 1'b0;
        sw_if.t_at_zero = 1'b0;
        sw_if.t_at_max  = 1'b0;

        test_reset();
        test_run_pause();
        test_prog();
        test_wrap();
        test_expire();
        test_blink();
        test_saturate();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Mode sequencer for the stopwatch time datapath. It turns the startstop, prog, increment, min, up and clear controls into count-enable, direction and load commands for the millisecond time counter, and owns the programmed countdown preset. It detects countdown expiry and up-count limit, raises the alarm, and drives the blinker during programming and alarm. It sits between the debounced button inputs and the time counter inside top.

Parameters:
TW, 23, width of time and preset values in ms
MAX_PRESET_MS, 5999000, largest programmable preset (99 min 59 s); preset wraps to 0 beyond it
SEC_STEP_MS, 1000, preset step when min=0
MIN_STEP_MS, 60000, preset step when min=1
BLINK_MS, 250, ms_tick count per blinker toggle

Ports:
clock  in  1  system clock, 100 MHz
reset  in  1  synchronous, active-high; returns block to IDLE
ms_tick  in  1  one-cycle strobe, once per ms
startstop  in  1  debounced level; rising edge = start/stop command
prog  in  1  level; 1 requests programming mode
increment  in  1  debounced level; rising edge = add step to preset
min  in  1  selects MIN_STEP_MS (1) or SEC_STEP_MS (0)
up  in  1  1 = count up, 0 = count down from preset
clear  in  1  level; user clear of the running time
t_at_zero  in  1  datapath time == 0
t_at_max  in  1  datapath time == MAX_PRESET_MS
cnt_en  out  1  advance the counter by 1 ms this cycle
cnt_up  out  1  counter direction
cnt_load  out  1  load load_val into the counter
load_val  out  TW  value to load: 0 if up=1, else preset
preset  out  TW  programmed countdown start value
alarm  out  1  countdown expired
blinker  out  1  display blink enable
state  out  3  IDLE=0, RUN=1, PAUSE=2, PROG=3, EXPIRED=4

Behaviour:
- Edge detect: ss_q and inc_q register startstop and increment. ss_edge = startstop & ~ss_q and inc_edge = increment & ~inc_q are combinational. State and preset react on the same clock edge that first samples the input high. A held level gives exactly one event.
- Reset: state=IDLE, preset=0, ss_q=inc_q=0, blink counter=0, blinker=0, alarm=0, cnt_en=0, cnt_load=1, cnt_up=up, load_val=0.
- cnt_up = up in every state (combinational). load_val = up ? 0 : preset (combinational).
- cnt_load = 1 in IDLE and PROG, 0 elsewhere.
- cnt_en = ms_tick & (state==RUN), 0 elsewhere.
- IDLE:
  - prog=1 -> PROG (prog takes priority over ss_edge).
  - else ss_edge -> RUN.
- PROG:
  - inc_edge: preset += step, where step = min ? MIN_STEP_MS : SEC_STEP_MS.
  - If the sum exceeds MAX_PRESET_MS, preset = 0 (wrap).
  - prog=0 -> IDLE. startstop is ignored.
- RUN (checks in priority order):
  1. clear -> IDLE
  2. ss_edge -> PAUSE
  3. up=0 and t_at_zero -> EXPIRED
  4. up=1 and t_at_max -> PAUSE (saturate)
  - Expiry is checked every cycle, not only on ms_tick. Entering RUN with up=0 and preset=0 expires on the next cycle.
- PAUSE:
  - clear -> IDLE.
  - else ss_edge -> RUN. If t_at_max with up=1 still holds, the block returns to PAUSE on the next cycle.
  - prog is ignored.
- EXPIRED:
  - alarm=1 and cnt_en=0.
  - clear or ss_edge -> IDLE; alarm drops when IDLE is entered.
- alarm is registered: it is 1 exactly while state==EXPIRED.
- Blinker:
  - In PROG and EXPIRED, the blink counter increments on ms_tick. When it reaches BLINK_MS-1 it resets to 0 and blinker toggles.
  - In any other state, the counter and blinker are held at 0.
  - On entry to PROG or EXPIRED, the counter starts from 0 and blinker starts at 0.
- Changing up mid-RUN changes cnt_up immediately; no state change results.
- min is sampled only on the inc_edge cycle.
- preset is retained across all states; only reset clears it.
- Reset asserted mid-RUN or mid-PROG overrides everything on that edge.

Test Plan:
- Reset, up=1, startstop pulse then 5 ms_ticks, then startstop pulse -> state 0→1→2; cnt_en pulses 5 times; cnt_load=1 only in IDLE.
- IDLE, prog=1, min=1, 2 increment pulses, min=0, 3 increment pulses, prog=0 -> preset=123000, state back to 0; with up=0, load_val=123000.
- PROG with preset=5940000, min=1, increment -> preset wraps to 0; a further increment with min=0 -> preset=1000.
- up=0, preset=1000, start, assert t_at_zero -> next edge state=4, alarm=1, cnt_en=0; startstop edge -> state=0, alarm=0.
- EXPIRED with BLINK_MS=4 and ms_tick every cycle -> blinker toggles every 4 cycles; RUN with clear=1 and a simultaneous ss_edge -> IDLE (clear wins).
- Holding startstop high for 20 cycles in IDLE -> exactly one transition to RUN; asserting reset during RUN -> IDLE, preset=0, alarm=0 on that edge.
